// File: rtl/debounce_pkg.sv
// Shared repeat-state encoding and default timing for a 100 MHz core clock.
// 1 ms stability window, 0.5 s initial repeat delay, 0.1 s repeat interval.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_NUM_CH        = 13;
  localparam int DEF_STABLE_CYCLES = 100000;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_RATE   = 10000000;
  localparam int DEF_CNT_W         = 27;
  localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_bank_if.sv
// Pad-side inputs and debounced level/pulse outputs of the debounce bank.
// Free-running, no handshake: every signal is valid on every clock.
interface debounce_bank_if #(
  parameter int NUM_CH = 13
);
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] repeat_en;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] repeat_pulse;
  logic              any_change;

  modport master (
    output raw_in, repeat_en,
    input  level_out, rise_pulse, fall_pulse, repeat_pulse, any_change
  );

  modport slave (
    input  raw_in, repeat_en,
    output level_out, rise_pulse, fall_pulse, repeat_pulse, any_change
  );
endinterface

// File: rtl/debounce_ch.sv
// One channel: synchroniser, stability counter, edge pulses and auto-repeat FSM.
// Level follows raw input after SYNC_STAGES+STABLE_CYCLES edges; no backpressure.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt,
  output logic flip
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       rcnt;
  logic [CNT_W-1:0]       rcnt_next;
  rpt_state_e             state;
  rpt_state_e             state_next;
  logic                   rpt_next;

  assign s    = sync_q[SYNC_STAGES-1];
  // flip is the registered-next view of an edge; the top uses it for any_change
  assign flip = (s != level) && (cnt == STABLE_LAST);

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rpt_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (flip && !level) begin
          state_next = DELAY;
          rcnt_next  = '0;
        end
      end
      DELAY: begin
        if (rcnt == DELAY_LAST) begin
          rpt_next   = 1'b1;
          state_next = REPEAT;
          rcnt_next  = '0;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (rcnt == RATE_LAST) begin
          rpt_next  = 1'b1;
          rcnt_next = '0;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Release or enable drop abandons the hold silently, overriding any due pulse
    if (!repeat_en || (flip && level)) begin
      state_next = IDLE;
      rcnt_next  = '0;
      rpt_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      rpt    <= 1'b0;
      state  <= IDLE;
      rcnt   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (s == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
      rise  <= flip & ~level;
      fall  <= flip & level;
      rpt   <= rpt_next;
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of NUM_CH independent debounce channels plus a registered any_change flag.
// Same latency as a single channel; free-running, no backpressure.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_bank_if.slave  io
);

  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] rpt;
  logic [NUM_CH-1:0] flip;
  logic              any_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (io.raw_in[i]),
      .repeat_en (io.repeat_en[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .rpt       (rpt[i]),
      .flip      (flip[i])
    );
  end

  // Registered from the channels' pending flips so it lands with the pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |flip;
    end
  end

  assign io.level_out    = level;
  assign io.rise_pulse   = rise;
  assign io.fall_pulse   = fall;
  assign io.repeat_pulse = rpt;
  assign io.any_change   = any_q;

endmodule
